// File: rtl/fetch_stage.sv
// Fetch stage: program-counter generator driving a combinational instruction memory,
// plus the IF/ID valid/ready register that feeds decode.
module fetch_stage #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           INSN_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [INSN_WIDTH-1:0] NOP_INSN   = INSN_WIDTH'(32'h0000_0013)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [INSN_WIDTH-1:0] imem_insn,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [INSN_WIDTH-1:0] id_insn,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic                  id_fault,
   output logic                  fetch_halted,
   output logic [31:0]           fetch_count
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  id_valid_q, id_valid_d;
   logic [INSN_WIDTH-1:0] id_insn_q, id_insn_d;
   logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
   logic                  id_fault_q, id_fault_d;
   logic                  halted_q, halted_d;
   logic [31:0]           count_q, count_d;

   logic misaligned;
   logic fire;

   assign misaligned = (pc_q[1:0] != 2'b00);
   // The IF/ID slot can be (re)filled when it is empty or being drained this cycle.
   assign fire = !redirect_valid && !halted_q && (!id_valid_q || id_ready);

   always_comb begin
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      id_insn_d  = id_insn_q;
      id_pc_d    = id_pc_q;
      id_fault_d = id_fault_q;
      halted_d   = halted_q;
      count_d    = count_q;

      if (redirect_valid) begin
         // Flush only; the stale slot payload is left in place since id_valid masks it.
         pc_d       = redirect_pc;
         id_valid_d = 1'b0;
         halted_d   = 1'b0;
      end else if (fire) begin
         id_valid_d = 1'b1;
         id_pc_d    = pc_q;
         if (count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
         end
         if (misaligned) begin
            id_insn_d  = NOP_INSN;
            id_fault_d = 1'b1;
            halted_d   = 1'b1;
         end else begin
            id_insn_d  = imem_insn;
            id_fault_d = 1'b0;
            pc_d       = pc_q + ADDR_WIDTH'(4);
         end
      end else if (id_valid_q && id_ready) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         id_valid_q <= 1'b0;
         id_insn_q  <= NOP_INSN;
         id_pc_q    <= '0;
         id_fault_q <= 1'b0;
         halted_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_insn_q  <= id_insn_d;
         id_pc_q    <= id_pc_d;
         id_fault_q <= id_fault_d;
         halted_q   <= halted_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr    = pc_q;
   assign id_valid     = id_valid_q;
   assign id_insn      = id_insn_q;
   assign id_pc        = id_pc_q;
   assign id_fault     = id_fault_q;
   assign fetch_halted = halted_q;
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: rule-level reference model feeding a scoreboard queue, checked by
// an independent monitor on each decode handshake; a second instance checks PC wrap.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        fault;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr, imem_insn;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid, id_ready = 1'b0;
   logic [31:0] id_insn, id_pc;
   logic        id_fault, fetch_halted;
   logic [31:0] fetch_count;

   logic [31:0] w_addr, w_insn, w_id_insn, w_id_pc, w_count;
   logic        w_id_valid, w_id_fault, w_halted;

   logic [31:0] mem [256];
   int          checks = 0;
   int          failures = 0;

   slot_t       exp_q[$];
   logic [31:0] m_pc = '0;
   logic        m_valid = 1'b0;
   logic        m_halted = 1'b0;
   logic [31:0] m_count = '0;

   always #5 clk = ~clk;

   assign imem_insn = mem[imem_addr[9:2]];
   assign w_insn    = mem[w_addr[9:2]];

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_insn      (imem_insn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_insn        (id_insn),
      .id_pc          (id_pc),
      .id_fault       (id_fault),
      .fetch_halted   (fetch_halted),
      .fetch_count    (fetch_count)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (w_addr),
      .imem_insn      (w_insn),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .id_valid       (w_id_valid),
      .id_ready       (1'b1),
      .id_insn        (w_id_insn),
      .id_pc          (w_id_pc),
      .id_fault       (w_id_fault),
      .fetch_halted   (w_halted),
      .fetch_count    (w_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour for one clock, from the current inputs and model state.
   task automatic model_cycle();
      logic  fire;
      logic  mis;
      slot_t s;
      fire = !redirect_valid && !m_halted && (!m_valid || id_ready);
      if (redirect_valid) begin
         if (m_valid && !id_ready && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
         m_pc     = redirect_pc;
         m_valid  = 1'b0;
         m_halted = 1'b0;
      end else if (fire) begin
         mis     = (m_pc % 4) != 0;
         s.pc    = m_pc;
         s.insn  = mis ? NOP : mem[m_pc[9:2]];
         s.fault = mis;
         exp_q.push_back(s);
         if (mis) m_halted = 1'b1;
         else     m_pc = m_pc + 32'd4;
         m_valid = 1'b1;
         if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      end else if (m_valid && id_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic step(input logic r, input logic rv, input logic [31:0] rpc);
      id_ready       = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      model_cycle();
      @(posedge clk);
      #1;
      chk("imem_addr", 64'(imem_addr), 64'(m_pc));
      chk("id_valid", 64'(id_valid), 64'(m_valid));
      chk("fetch_halted", 64'(fetch_halted), 64'(m_halted));
      chk("fetch_count", 64'(fetch_count), 64'(m_count));
   endtask

   // Monitor: every decode handshake consumes the oldest expected slot.
   always @(negedge clk) begin
      if (rst_n && id_valid && id_ready) begin
         if (exp_q.size() == 0) begin
            chk("slot_unexpected", 64'(id_pc), 64'hDEAD);
         end else begin
            slot_t s;
            s = exp_q.pop_front();
            chk("id_pc", 64'(id_pc), 64'(s.pc));
            chk("id_insn", 64'(id_insn), 64'(s.insn));
            chk("id_fault", 64'(id_fault), 64'(s.fault));
         end
      end
   end

   initial begin
      @(posedge rst_n);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] e;
         e = 32'hFFFF_FFF8 + 32'(4 * i);
         @(posedge clk);
         #1;
         chk("wrap_valid", 64'(w_id_valid), 64'd1);
         chk("wrap_pc", 64'(w_id_pc), 64'(e));
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(i);

      #12;
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_insn", 64'(id_insn), 64'(NOP));
      chk("rst_id_pc", 64'(id_pc), 64'd0);
      chk("rst_id_fault", 64'(id_fault), 64'd0);
      chk("rst_count", 64'(fetch_count), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming, stall, stalled-slot redirect, misaligned halt and recovery.
      repeat (3) step(1'b1, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h40);
      step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h42);
      step(1'b1, 1'b0, 32'h0);
      repeat (2) step(1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h80);
      repeat (3) step(1'b1, 1'b0, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         logic [31:0] rpc;
         r = $urandom_range(0, 99);
         if (r < 60)      rpc = 32'($urandom_range(0, 255)) << 2;
         else if (r < 80) rpc = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
         else             rpc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
         step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, rpc);
      end

      // Asynchronous reset while a slot is held.
      step(1'b0, 1'b1, 32'h100);
      step(1'b0, 1'b0, 32'h0);
      chk("pre_rst_valid", 64'(id_valid), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_id_valid", 64'(id_valid), 64'd0);
      chk("async_addr", 64'(imem_addr), 64'd0);
      chk("async_count", 64'(fetch_count), 64'd0);
      chk("async_halted", 64'(fetch_halted), 64'd0);
      m_pc     = '0;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_count  = '0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step(1'b1, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter generator and IF/ID pipeline register.
- Sits directly upstream of the instruction memory and drives its word address. The memory is combinational: the instruction returns in the same cycle, indexed by address bits [9:2].
- Latches the returned instruction with its PC into a valid/ready register that feeds decode.
- Handles decode back-pressure, branch/jump redirects, misaligned-target faults and a fetch counter.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- INSN_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INSN, 32'h0000_0013, instruction emitted on fault or at reset (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- imem_addr  output  ADDR_WIDTH  address to instruction memory; always equals pc.
- imem_insn  input  INSN_WIDTH  instruction returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  input  ADDR_WIDTH  redirect target.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decode accepts the IF/ID contents this cycle.
- id_insn  output  INSN_WIDTH  registered instruction.
- id_pc  output  ADDR_WIDTH  PC of id_insn.
- id_fault  output  1  id_insn is a misaligned-fetch fault slot.
- fetch_halted  output  1  fetch stopped after a fault; waits for a redirect.
- fetch_count  output  32  number of instructions loaded into IF/ID; saturates.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC
  - id_valid=0, id_insn=NOP_INSN, id_pc=0, id_fault=0
  - fetch_halted=0, fetch_count=0
- imem_addr=pc is combinational from the pc register; no other logic sits in that path.
- misaligned = (pc[1:0]!=0).
- fire = !redirect_valid & !fetch_halted & (!id_valid | id_ready).
- Priority per cycle: redirect, then fire, then hold.
- redirect_valid=1, regardless of id_ready or halt:
  - pc<=redirect_pc
  - id_valid<=0 (flush)
  - fetch_halted<=0
  - fetch_count unchanged
  - id_insn, id_pc and id_fault hold their old values.
- fire with misaligned=0:
  - id_valid<=1, id_insn<=imem_insn, id_pc<=pc, id_fault<=0
  - pc<=pc+4, modulo 2^ADDR_WIDTH (0xFFFF_FFFC wraps to 0x0)
  - fetch_count+1
- fire with misaligned=1:
  - id_valid<=1, id_insn<=NOP_INSN, id_pc<=pc, id_fault<=1
  - pc holds
  - fetch_halted<=1
  - fetch_count+1
- No fire, no redirect:
  - If id_valid & id_ready: id_valid<=0. This covers consuming the last slot while halted.
  - Otherwise all state holds. id_insn, id_pc and id_fault are stable while id_valid & !id_ready.
- Throughput: one instruction per cycle when id_ready=1 continuously.
  - Latency from pc update to id_valid is 1 cycle.
  - First id_valid after reset is 1 cycle after rst_n deasserts.
- Redirect in the same cycle as a decode handshake: the handshake completes (decode took the slot), and the register still flushes.
- fetch_count saturates at 32'hFFFF_FFFF.
- The fetch stage never re-reads memory for a stalled slot; the instruction is captured once.

Test Plan:
- Reset release, RESET_PC=0, mem[i]=0x1000+i, id_ready=1 -> imem_addr 0,4,8,...; id_valid rises 1 cycle after reset; id_pc/id_insn = 0/0x1000, 4/0x1001, 8/0x1002 on consecutive cycles; fetch_count=3 after 3 fires.
- Hold id_ready=0 for 3 cycles with id_valid=1, id_pc=8 -> id_pc=8 and id_insn=0x1002 stable; imem_addr stays 0xC; fetch_count unchanged. Release -> next slot has id_pc=0xC.
- Stalled slot (id_ready=0) plus redirect_valid=1, redirect_pc=0x40 -> next cycle id_valid=0, imem_addr=0x40. Following cycle id_pc=0x40, id_insn=mem[16].
- Redirect to 0x42 -> slot with id_pc=0x42, id_fault=1, id_insn=0x13. fetch_halted=1 and pc holds at 0x42. After decode consumes the slot, id_valid=0 and stays 0. Redirect to 0x80 clears the halt; id_pc=0x80 follows.
- RESET_PC=0xFFFF_FFF8 -> id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert rst_n=0 mid-stream while id_valid=1 -> id_valid=0, pc=RESET_PC and fetch_count=0 immediately, without waiting for a clock edge.
